// File: rtl/mips_mc_control.sv
// Multicycle MIPS control unit: steps each instruction through fetch, decode,
// execute, memory and writeback, and drives the datapath selects and enables.
// Outputs are a decode of the current state. They are gated by mem_ready in
// FETCH and by zero in BRANCH.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// FETCH    | read instruction at PC, PC += 4 when memory is ready
// DECODE   | read registers, precompute branch target, dispatch on opcode
// MEMADR   | compute load/store address A + signext(imm)
// MEMRD    | load read access, wait for mem_ready
// MEMWB    | write loaded data to rt
// MEMWR    | store write access, wait for mem_ready
// EXECUTE  | R-type ALU operation A op B
// ALUWB    | write ALU result to rd
// BRANCH   | compare A - B, take branch when zero
// ADDIEXEC | A + signext(imm)
// ADDIWB   | write ALU result to rt
// JUMP     | load jump target into PC
module mips_mc_control #(
    parameter int unsigned STALL_TIMEOUT = 0
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] alucontrol,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic [1:0] pcsrc,
    output logic       pcen,
    output logic       irwrite,
    output logic       iord,
    output logic       memwrite,
    output logic       regwrite,
    output logic       regdst,
    output logic       memtoreg,
    output logic       illegal_op,
    output logic       mem_err,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMRD    = 4'd3,
        MEMWB    = 4'd4,
        MEMWR    = 4'd5,
        EXECUTE  = 4'd6,
        ALUWB    = 4'd7,
        BRANCH   = 4'd8,
        ADDIEXEC = 4'd9,
        ADDIWB   = 4'd10,
        JUMP     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam bit          TMO_EN     = (STALL_TIMEOUT != 0);
    // Stall count already accumulated when the current stall cycle is the last allowed
    localparam logic [15:0] STALL_LAST = 16'(STALL_TIMEOUT - 1);

    state_t      state_q;
    state_t      state_nx;
    logic [15:0] stall_cnt;
    logic        stall_state;
    logic        timeout;
    logic        illegal;
    logic        funct_ok;
    logic [2:0]  alu_funct;

    assign state       = state_q;
    assign stall_state = (state_q == FETCH) || (state_q == MEMRD) || (state_q == MEMWR);
    assign timeout     = TMO_EN && reset_n && stall_state && !mem_ready && (stall_cnt == STALL_LAST);

    // R-type funct decode: ALU op and legality
    always_comb begin
        funct_ok  = 1'b1;
        alu_funct = 3'b010;
        case (funct)
            6'b100000: alu_funct = 3'b010;
            6'b100010: alu_funct = 3'b110;
            6'b100100: alu_funct = 3'b000;
            6'b100101: alu_funct = 3'b001;
            6'b101010: alu_funct = 3'b111;
            default:   funct_ok  = 1'b0;
        endcase
    end

    // Next-state selection; a stall timeout overrides everything and returns to FETCH
    always_comb begin
        state_nx = FETCH;
        illegal  = 1'b0;
        case (state_q)
            FETCH:    state_nx = mem_ready ? DECODE : FETCH;
            DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_nx = MEMADR;
                    OP_RTYPE: begin
                        if (funct_ok) state_nx = EXECUTE;
                        else          illegal  = 1'b1;
                    end
                    OP_BEQ:   state_nx = BRANCH;
                    OP_ADDI:  state_nx = ADDIEXEC;
                    OP_J:     state_nx = JUMP;
                    default:  illegal  = 1'b1;
                endcase
            end
            MEMADR:   state_nx = (opcode == OP_LW) ? MEMRD : MEMWR;
            MEMRD:    state_nx = mem_ready ? MEMWB : MEMRD;
            MEMWB:    state_nx = FETCH;
            MEMWR:    state_nx = mem_ready ? FETCH : MEMWR;
            EXECUTE:  state_nx = ALUWB;
            ALUWB:    state_nx = FETCH;
            BRANCH:   state_nx = FETCH;
            ADDIEXEC: state_nx = ADDIWB;
            ADDIWB:   state_nx = FETCH;
            JUMP:     state_nx = FETCH;
            default:  state_nx = FETCH;
        endcase
        if (timeout) state_nx = FETCH;
    end

    // State register and stall counter; the counter restarts on every state change
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= FETCH;
            stall_cnt <= '0;
        end else begin
            state_q <= state_nx;
            if (timeout || (state_nx != state_q))
                stall_cnt <= '0;
            else if (stall_state && !mem_ready)
                stall_cnt <= stall_cnt + 16'd1;
        end
    end

    // Datapath control decode; write enables are killed by timeout and by reset
    always_comb begin
        alucontrol = 3'b000;
        alusrca    = 1'b0;
        alusrcb    = 2'b00;
        pcsrc      = 2'b00;
        pcen       = 1'b0;
        irwrite    = 1'b0;
        iord       = 1'b0;
        memwrite   = 1'b0;
        regwrite   = 1'b0;
        regdst     = 1'b0;
        memtoreg   = 1'b0;
        case (state_q)
            FETCH: begin
                alusrcb    = 2'b01;
                alucontrol = 3'b010;
                irwrite    = mem_ready;
                pcen       = mem_ready;
            end
            DECODE: begin
                alusrcb    = 2'b11;
                alucontrol = 3'b010;
            end
            MEMADR, ADDIEXEC: begin
                alusrca    = 1'b1;
                alusrcb    = 2'b10;
                alucontrol = 3'b010;
            end
            MEMRD:   iord = 1'b1;
            MEMWB: begin
                regwrite = 1'b1;
                memtoreg = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            EXECUTE: begin
                alusrca    = 1'b1;
                alucontrol = alu_funct;
            end
            ALUWB: begin
                regwrite = 1'b1;
                regdst   = 1'b1;
            end
            BRANCH: begin
                alusrca    = 1'b1;
                alucontrol = 3'b110;
                pcsrc      = 2'b01;
                pcen       = zero;
            end
            ADDIWB:  regwrite = 1'b1;
            JUMP: begin
                pcsrc = 2'b10;
                pcen  = 1'b1;
            end
            default: ;
        endcase
        if (timeout || !reset_n) begin
            pcen     = 1'b0;
            irwrite  = 1'b0;
            memwrite = 1'b0;
            regwrite = 1'b0;
        end
        illegal_op = illegal;
        mem_err    = timeout;
    end

endmodule

// File: tb/tb_mips_mc_control.sv
// Bench for mips_mc_control: two instances (timeout disabled, timeout = 2),
// each driven by an instruction-level reference model that pushes the expected
// per-cycle output vector into a queue; a negedge monitor pops and compares.
module tb_mips_mc_control;

    localparam int TMO1 = 2;

    localparam logic [5:0] LW   = 6'b100011;
    localparam logic [5:0] SW   = 6'b101011;
    localparam logic [5:0] RT   = 6'b000000;
    localparam logic [5:0] BEQ  = 6'b000100;
    localparam logic [5:0] ADDI = 6'b001000;
    localparam logic [5:0] JMP  = 6'b000010;

    logic       clk;
    logic       reset_n    [2];
    logic [5:0] opcode     [2];
    logic [5:0] funct      [2];
    logic       zero       [2];
    logic       mem_ready  [2];
    logic [2:0] alucontrol [2];
    logic       alusrca    [2];
    logic [1:0] alusrcb    [2];
    logic [1:0] pcsrc      [2];
    logic       pcen       [2];
    logic       irwrite    [2];
    logic       iord       [2];
    logic       memwrite   [2];
    logic       regwrite   [2];
    logic       regdst     [2];
    logic       memtoreg   [2];
    logic       illegal_op [2];
    logic       mem_err    [2];
    logic [3:0] state      [2];

    int          tmo_cfg [2];
    logic [20:0] q0 [$];
    logic [20:0] q1 [$];
    int          checks = 0;
    int          errors = 0;
    logic [5:0]  legal_fn [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};

    mips_mc_control u_dut0 (
        .clk(clk), .reset_n(reset_n[0]), .opcode(opcode[0]), .funct(funct[0]),
        .zero(zero[0]), .mem_ready(mem_ready[0]), .alucontrol(alucontrol[0]),
        .alusrca(alusrca[0]), .alusrcb(alusrcb[0]), .pcsrc(pcsrc[0]), .pcen(pcen[0]),
        .irwrite(irwrite[0]), .iord(iord[0]), .memwrite(memwrite[0]),
        .regwrite(regwrite[0]), .regdst(regdst[0]), .memtoreg(memtoreg[0]),
        .illegal_op(illegal_op[0]), .mem_err(mem_err[0]), .state(state[0])
    );

    mips_mc_control #(.STALL_TIMEOUT(TMO1)) u_dut1 (
        .clk(clk), .reset_n(reset_n[1]), .opcode(opcode[1]), .funct(funct[1]),
        .zero(zero[1]), .mem_ready(mem_ready[1]), .alucontrol(alucontrol[1]),
        .alusrca(alusrca[1]), .alusrcb(alusrcb[1]), .pcsrc(pcsrc[1]), .pcen(pcen[1]),
        .irwrite(irwrite[1]), .iord(iord[1]), .memwrite(memwrite[1]),
        .regwrite(regwrite[1]), .regdst(regdst[1]), .memtoreg(memtoreg[1]),
        .illegal_op(illegal_op[1]), .mem_err(mem_err[1]), .state(state[1])
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: run did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    function automatic logic [20:0] got_of(input int i);
        return {state[i], alucontrol[i], alusrca[i], alusrcb[i], pcsrc[i], pcen[i], irwrite[i],
                iord[i], memwrite[i], regwrite[i], regdst[i], memtoreg[i], illegal_op[i], mem_err[i]};
    endfunction

    function automatic bit fn_legal(input logic [5:0] fn);
        for (int k = 0; k < 5; k++) if (legal_fn[k] == fn) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit op_known(input logic [5:0] op);
        return (op == LW) || (op == SW) || (op == RT) || (op == BEQ) || (op == ADDI) || (op == JMP);
    endfunction

    function automatic logic [2:0] alu_of(input logic [5:0] fn);
        case (fn)
            6'b100000: return 3'b010;
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            default:   return 3'b111;
        endcase
    endfunction

    // Expected output vector for one cycle spent in phase s
    function automatic logic [20:0] expect_out(input int s, input bit mr, input bit z,
                                               input logic [5:0] fn, input bit ill, input bit tmo);
        logic [2:0] ac = 3'b000;
        logic       a = 1'b0;
        logic [1:0] b = 2'b00;
        logic [1:0] pc = 2'b00;
        logic       pe = 1'b0, irw = 1'b0, io = 1'b0, mw = 1'b0, rw = 1'b0, rd = 1'b0, m2r = 1'b0;
        case (s)
            0:  begin b = 2'b01; ac = 3'b010; irw = mr & ~tmo; pe = mr & ~tmo; end
            1:  begin b = 2'b11; ac = 3'b010; end
            2:  begin a = 1'b1; b = 2'b10; ac = 3'b010; end
            3:  io = 1'b1;
            4:  begin rw = 1'b1; m2r = 1'b1; end
            5:  begin io = 1'b1; mw = ~tmo; end
            6:  begin a = 1'b1; ac = alu_of(fn); end
            7:  begin rw = 1'b1; rd = 1'b1; end
            8:  begin a = 1'b1; ac = 3'b110; pc = 2'b01; pe = z; end
            9:  begin a = 1'b1; b = 2'b10; ac = 3'b010; end
            10: rw = 1'b1;
            11: begin pc = 2'b10; pe = 1'b1; end
            default: ;
        endcase
        return {4'(s), ac, a, b, pc, pe, irw, io, mw, rw, rd, m2r, ill, tmo};
    endfunction

    task automatic push(input int idx, input logic [20:0] e);
        if (idx == 0) q0.push_back(e);
        else          q1.push_back(e);
    endtask

    task automatic compare(input int i, input logic [20:0] e);
        logic [20:0] g;
        g = got_of(i);
        checks++;
        if (g !== e) begin
            errors++;
            $display("FAIL dut%0d outputs: got state=%0d vec=%b, expected state=%0d vec=%b",
                     i, g[20:17], g, e[20:17], e);
        end
    endtask

    always @(negedge clk) begin
        if (q0.size() > 0) compare(0, q0.pop_front());
        if (q1.size() > 0) compare(1, q1.pop_front());
    end

    task automatic do_reset(input int idx, input int n);
        repeat (n) begin
            @(posedge clk); #1;
            reset_n[idx]   = 1'b0;
            mem_ready[idx] = 1'b1;
            zero[idx]      = 1'($urandom_range(0, 1));
            push(idx, expect_out(0, 1'b0, 1'b0, 6'd0, 1'b0, 1'b0));
        end
    endtask

    // One instruction: phase list from the instruction class, one expectation per cycle.
    // zf < 0 randomizes zero; rst_at >= 0 asserts reset at that cycle and ends the instruction.
    task automatic run_instr(input int idx, input logic [5:0] op, input logic [5:0] fn,
                             input bit rand_mr, input int stall_n, input int rst_at, input int zf);
        int ph [6];
        int n, p, stall, cyc, stall_left, s;
        bit ill, waiting, mr, z, tmo;
        ill = 1'b0; ph[0] = 0; ph[1] = 1; n = 2;
        for (int k = 2; k < 6; k++) ph[k] = 0;
        case (op)
            LW:   begin ph[2] = 2; ph[3] = 3; ph[4] = 4; n = 5; end
            SW:   begin ph[2] = 2; ph[3] = 5; n = 4; end
            RT:   if (fn_legal(fn)) begin ph[2] = 6; ph[3] = 7; n = 4; end else ill = 1'b1;
            BEQ:  begin ph[2] = 8; n = 3; end
            ADDI: begin ph[2] = 9; ph[3] = 10; n = 4; end
            JMP:  begin ph[2] = 11; n = 3; end
            default: ill = 1'b1;
        endcase
        p = 0; stall = 0; cyc = 0; stall_left = stall_n;
        while (p < n) begin
            @(posedge clk); #1;
            s = ph[p];
            waiting = (s == 0) || (s == 3) || (s == 5);
            if (waiting && s != 0 && stall_left > 0) begin
                mr = 1'b0;
                stall_left--;
            end else if (waiting && !rand_mr) mr = 1'b1;
            else if (waiting) mr = ($urandom_range(0, 9) < 7);
            else mr = 1'($urandom_range(0, 1));
            z = (zf < 0) ? 1'($urandom_range(0, 1)) : 1'(zf);
            opcode[idx] = op; funct[idx] = fn; mem_ready[idx] = mr; zero[idx] = z;
            if (cyc == rst_at) begin
                reset_n[idx] = 1'b0;
                push(idx, expect_out(0, 1'b0, 1'b0, fn, 1'b0, 1'b0));
                return;
            end
            reset_n[idx] = 1'b1;
            tmo = waiting && !mr && (tmo_cfg[idx] != 0) && (stall + 1 == tmo_cfg[idx]);
            push(idx, expect_out(s, mr, z, fn, ill && (s == 1), tmo));
            if (tmo) p = n;
            else if (waiting && !mr) stall++;
            else begin p++; stall = 0; end
            cyc++;
        end
    endtask

    task automatic drive_seq(input int idx);
        logic [5:0] op, fn;
        int r;
        do_reset(idx, 2);
        run_instr(idx, LW, 6'b010101, 1'b0, 0, -1, -1);
        for (int k = 0; k < 5; k++) run_instr(idx, RT, legal_fn[k], 1'b0, 0, -1, -1);
        run_instr(idx, BEQ, 6'b000000, 1'b0, 0, -1, 1);
        run_instr(idx, BEQ, 6'b000000, 1'b0, 0, -1, 0);
        run_instr(idx, ADDI, 6'b111000, 1'b0, 0, -1, -1);
        run_instr(idx, JMP, 6'b000001, 1'b0, 0, -1, -1);
        run_instr(idx, SW, 6'b100010, 1'b0, 3, -1, -1);
        run_instr(idx, LW, 6'b000011, 1'b0, 2, -1, -1);
        run_instr(idx, 6'b111111, 6'b100000, 1'b0, 0, -1, -1);
        run_instr(idx, RT, 6'b000111, 1'b0, 0, -1, -1);
        run_instr(idx, SW, 6'b000000, 1'b0, 5, 4, -1);
        do_reset(idx, 1);
        run_instr(idx, LW, 6'b000000, 1'b0, 0, -1, -1);
        for (int k = 0; k < 150; k++) begin
            r  = $urandom_range(0, 7);
            fn = 6'($urandom_range(0, 63));
            case (r)
                0: op = LW;
                1: op = SW;
                2: begin op = RT; fn = legal_fn[$urandom_range(0, 4)]; end
                3: op = BEQ;
                4: op = ADDI;
                5: op = JMP;
                6: begin
                    op = 6'($urandom_range(0, 63));
                    while (op_known(op)) op = 6'($urandom_range(0, 63));
                end
                default: begin
                    op = RT;
                    while (fn_legal(fn)) fn = 6'($urandom_range(0, 63));
                end
            endcase
            run_instr(idx, op, fn, 1'b1, 0, -1, -1);
        end
    endtask

    initial begin
        tmo_cfg[0] = 0;
        tmo_cfg[1] = TMO1;
        for (int i = 0; i < 2; i++) begin
            reset_n[i]   = 1'b0;
            opcode[i]    = 6'd0;
            funct[i]     = 6'd0;
            zero[i]      = 1'b0;
            mem_ready[i] = 1'b1;
        end
        fork
            drive_seq(0);
            drive_seq(1);
        join
        @(negedge clk); #1;
        checks++;
        if (q0.size() + q1.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q0.size() + q1.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
